ex_muldiv: RTL and testbench



---
 rtl/ex_muldiv.sv | 124 ++++++++++++
 tb/tb_ex_muldiv.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply/divide unit for the EX stage: shift-add multiplier
// and restoring divider, one bit per cycle, result returned with a one-cycle done pulse.
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inStart,
  input  logic [1:0]       inOp,
  input  logic [WIDTH-1:0] inR1,
  input  logic [WIDTH-1:0] inR2,
  input  logic [4:0]       inWriteRegister,
  output logic             outBusy,
  output logic             outDone,
  output logic [WIDTH-1:0] outResult,
  output logic [4:0]       outWriteRegister
);

  // Handshake: a request (inStart) is taken on any edge where the unit is not
  // busy (IDLE or DONE); outBusy=1 tells ID/EX to hold, outDone is a one-cycle
  // valid pulse with no back-pressure, and outResult holds until the next pulse.

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [4:0]       r_wr;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_wr_out;

  logic             w_accept;
  logic             w_last;
  logic             w_is_div;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_lo_nx;
  logic [WIDTH-1:0] w_result_nx;

  assign w_accept = inStart && (r_state != S_RUN);
  assign w_last   = (r_cnt == LAST);
  assign w_is_div = r_op[1];

  // Multiply: r_hi:r_lo is the product with the multiplier draining out of r_lo.
  // Divide: r_hi is the remainder, r_lo shifts the dividend out and the quotient in.
  always_comb begin
    w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift  = {r_hi, r_lo[WIDTH-1]};
    w_borrow = (w_shift < {1'b0, r_b});
    w_diff   = w_shift[WIDTH-1:0] - r_b;
    if (w_is_div) begin
      w_hi_nx = w_borrow ? w_shift[WIDTH-1:0] : w_diff;
      w_lo_nx = {r_lo[WIDTH-2:0], ~w_borrow};
    end else begin
      w_hi_nx = w_add[WIDTH:1];
      w_lo_nx = {w_add[0], r_lo[WIDTH-1:1]};
    end
    case (r_op)
      2'b00:   w_result_nx = w_lo_nx;
      2'b01:   w_result_nx = w_hi_nx;
      2'b10:   w_result_nx = w_lo_nx;
      default: w_result_nx = w_hi_nx;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (inStart) w_state_nx = S_RUN;
      S_RUN:   if (w_last) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = inStart ? S_RUN : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_wr     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_wr_out <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_op  <= inOp;
        r_wr  <= inWriteRegister;
        r_cnt <= '0;
        r_hi  <= '0;
        r_b   <= inOp[1] ? inR2 : inR1;
        r_lo  <= inOp[1] ? inR1 : inR2;
      end else if (r_state == S_RUN) begin
        r_hi <= w_hi_nx;
        r_lo <= w_lo_nx;
        if (w_last) begin
          r_result <= w_result_nx;
          r_wr_out <= r_wr;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign outBusy          = (r_state == S_RUN);
  assign outDone          = (r_state == S_DONE);
  assign outResult        = r_result;
  assign outWriteRegister = r_wr_out;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: vector table plus hand-written sequences for back-to-back,
// ignored start, and reset during an operation; results checked through a queue.
module tb_ex_muldiv;

  logic        clk;
  logic        reset;
  logic        inStart;
  logic [1:0]  inOp;
  logic [31:0] inR1;
  logic [31:0] inR2;
  logic [4:0]  inWriteRegister;
  logic        outBusy;
  logic        outDone;
  logic [31:0] outResult;
  logic [4:0]  outWriteRegister;

  ex_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
    .clock           (clk),
    .reset           (reset),
    .inStart         (inStart),
    .inOp            (inOp),
    .inR1            (inR1),
    .inR2            (inR2),
    .inWriteRegister (inWriteRegister),
    .outBusy         (outBusy),
    .outDone         (outDone),
    .outResult       (outResult),
    .outWriteRegister(outWriteRegister)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   return prod[31:0];
      2'b01:   return prod[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // scoreboard: pop one expected {rd, result} per done pulse
  always @(negedge clk) begin
    if (outDone) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(outDone), 64'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("result", 64'(outResult), 64'(e[31:0]));
        check("write_register", 64'(outWriteRegister), 64'(e[36:32]));
      end
    end
  end

  // driver: assert start now (caller sits at a negedge), release at the next negedge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push);
    inStart = 1'b1;
    inOp = op;
    inR1 = a;
    inR2 = b;
    inWriteRegister = rd;
    if (push) exp_q.push_back({rd, model(op, a, b)});
    @(negedge clk);
    inStart = 1'b0;
    inR1 = $urandom;
    inR2 = $urandom;
  endtask

  // called at negedge of cycle start_cyc after acceptance; returns in the DONE cycle
  task automatic wait_done(input string name, input int start_cyc);
    int cyc;
    int busy;
    cyc  = start_cyc;
    busy = 0;
    while (!outDone && cyc < 40) begin
      if (outBusy) busy++;
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'd33);
    check({name, "_busy_cycles"}, 64'(busy), 64'(33 - start_cyc));
    check({name, "_busy_in_done"}, 64'(outBusy), 64'd0);
  endtask

  initial begin
    int dones;
    reset = 1'b0;
    inStart = 1'b0;
    inOp = 2'b00;
    inR1 = '0;
    inR2 = '0;
    inWriteRegister = '0;

    vecs[0] = '{2'b00, 32'd7,          32'd6,          5'd5,  32'd42};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'hFFFF_FFFE};
    vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  32'h0000_0001};
    vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd8,  32'd14};
    vecs[4] = '{2'b11, 32'd100,        32'd7,          5'd9,  32'd2};
    vecs[5] = '{2'b10, 32'h8000_0000,  32'd1,          5'd10, 32'h8000_0000};
    vecs[6] = '{2'b10, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF};
    vecs[7] = '{2'b11, 32'd5,          32'd0,          5'd12, 32'd5};
    vecs[8] = '{2'b00, 32'd0,          32'hDEAD_BEEF,  5'd0,  32'd0};
    vecs[9] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0000,  5'd31, 32'h7FFF_FFFF};

    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outputs", 64'({outBusy, outDone, outResult, outWriteRegister}), 64'd0);
    end

    // constant vector table
    for (int i = 0; i < 10; i++) begin
      check("table_model", 64'(model(vecs[i].op, vecs[i].a, vecs[i].b)), 64'(vecs[i].exp));
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1);
      wait_done("table", 1);
      if (i == 0) begin
        repeat (3) @(negedge clk);
        check("hold_result_idle", 64'({outWriteRegister, outResult}), 64'({5'd5, 32'd42}));
      end
    end

    // random operations, including small divisors and zero
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      @(negedge clk);
      issue(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)), 1'b1);
      wait_done("random", 1);
    end

    // start pulsed at RUN cycle 10 is ignored
    @(negedge clk);
    issue(2'b00, 32'd7, 32'd6, 5'd3, 1'b1);
    repeat (9) @(negedge clk);
    check("run_busy_at_cycle10", 64'(outBusy), 64'd1);
    issue(2'b10, 32'd999, 32'd3, 5'd20, 1'b0);
    wait_done("ignored_start", 11);

    // back-to-back: start held in the DONE cycle
    issue(2'b11, 32'd100, 32'd7, 5'd4, 1'b1);
    check("b2b_busy_immediate", 64'(outBusy), 64'd1);
    check("hold_result_run", 64'({outWriteRegister, outResult}), 64'({5'd3, 32'd42}));
    wait_done("back_to_back", 1);

    // reset during RUN discards the operation
    @(negedge clk);
    issue(2'b00, 32'd12345, 32'd678, 5'd17, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_run_outputs", 64'({outBusy, outDone, outResult, outWriteRegister}), 64'd0);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (outDone || outBusy) dones++;
    end
    check("no_done_after_reset", 64'(dones), 64'd0);

    @(negedge clk);
    issue(2'b00, 32'd3, 32'd3, 5'd1, 1'b1);
    wait_done("after_reset", 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
